// File: rtl/bp_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_slave_pkg
// Purpose  : Shared types and constants for the back-pressure slave:
//            mode and state encodings, LFSR feedback polynomial and step.
// Revision : 1.0  initial release
// ============================================================================
package bp_slave_pkg;

  // Ready-behaviour modes selected by cfg_mode
  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Handshake FSM states
  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_STALL  = 1'b1
  } state_e;

  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
  localparam logic [7:0] c_lfsr_poly = 8'hB8;

  // One LFSR step: shift toward bit 0, fold the feedback taps in on a 1 out
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? c_lfsr_poly : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : bp_lfsr
// Purpose  : 8-bit maximal-length Galois LFSR with reset seed and enable.
// Revision : 1.0  initial release
// ============================================================================
module bp_lfsr
  import bp_slave_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;

  // Advance the sequence on every enabled edge; restart from the seed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/bp_slave.sv
`default_nettype none
// ============================================================================
// Module   : bp_slave
// Purpose  : Valid/ready sink that counts beats into bursts, sums accepted
//            data, and applies configurable back-pressure between bursts
//            (none, fixed, pseudo-random, or hold-off).
// Revision : 1.0  initial release
// ============================================================================
module bp_slave
  import bp_slave_pkg::*;
#(
  parameter int         DATA_W    = 4,
  parameter int         BURST_LEN = 10,
  parameter int         STALL_MIN = 5,
  parameter int         STALL_MAX = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        cfg_mode,
  output logic              ready,
  output logic              burst_done,
  output logic [7:0]        beat_cnt,
  output logic [15:0]       checksum
);

  // Reject parameter sets the datapath cannot represent
  generate
    if (STALL_MIN < 1 || STALL_MAX < STALL_MIN || STALL_MAX > 255 ||
        LFSR_SEED == 8'h00 || DATA_W < 1 || DATA_W > 32 ||
        BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_params
      $fatal(1, "bp_slave: illegal parameter combination");
    end
  endgenerate

  localparam logic [7:0] c_last  = 8'(BURST_LEN - 1);
  localparam logic [7:0] c_min   = 8'(STALL_MIN);
  localparam logic [8:0] c_range = 9'(STALL_MAX - STALL_MIN + 1);

  mode_e       w_mode;
  state_e      state_q, state_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [7:0]  stall_n_q, stall_n_d;
  logic        hold_q;
  logic [7:0]  beat_q;
  logic [15:0] sum_q;
  logic        done_q;
  logic [7:0]  w_lfsr;
  logic [8:0]  w_mod;
  logic [7:0]  w_n_new;
  logic        w_hs;
  logic        w_last;

  bp_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .lfsr_o (w_lfsr)
  );

  assign w_mode  = mode_e'(cfg_mode);
  assign w_hs    = valid && (state_q == ST_ACCEPT);
  assign w_last  = w_hs && (beat_q == c_last);
  // Stall length offered at this edge, used only if a stall starts now
  assign w_mod   = {1'b0, w_lfsr} % c_range;
  assign w_n_new = (w_mode == MODE_RANDOM) ? (c_min + 8'(w_mod)) : c_min;

  // FSM state register with the stall length/counter and hold history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_STALL;
      stall_cnt_q <= 8'd0;
      stall_n_q   <= c_min;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_n_q   <= stall_n_d;
      hold_q      <= (w_mode == MODE_HOLD);
    end
  end

  // Next state: HOLD overrides everything; a stall runs N cycles from its start edge
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_n_d   = stall_n_q;
    if (w_mode == MODE_HOLD) begin
      state_d     = ST_STALL;
      stall_cnt_d = 8'd0;
    end else if (state_q == ST_ACCEPT) begin
      if (w_last && (w_mode != MODE_ALWAYS)) begin
        state_d     = ST_STALL;
        stall_cnt_d = 8'd0;
        stall_n_d   = w_n_new;
      end
    end else if (w_mode == MODE_ALWAYS) begin
      state_d = ST_ACCEPT;
    end else if (hold_q) begin
      // First edge after a hold-off starts a fresh stall
      stall_cnt_d = 8'd0;
      stall_n_d   = w_n_new;
    end else if (stall_cnt_q == stall_n_q - 8'd1) begin
      state_d = ST_ACCEPT;
    end else begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // Beat counting, running checksum and the end-of-burst pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= 8'd0;
      sum_q  <= 16'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= w_last;
      if (w_hs) begin
        sum_q  <= sum_q + 16'(data);
        beat_q <= w_last ? 8'd0 : (beat_q + 8'd1);
      end
    end
  end

  // Outputs are straight from registers
  always_comb begin
    ready      = (state_q == ST_ACCEPT);
    burst_done = done_q;
    beat_cnt   = beat_q;
    checksum   = sum_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_slave
// Purpose  : Self-checking bench for bp_slave: directed table, randomized
//            traffic against a behavioural model, and corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_slave;

  localparam int BL    = 10;
  localparam int SMIN  = 5;
  localparam int SMAX  = 10;
  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [1:0] M_ALWAYS = 2'd0;
  localparam logic [1:0] M_FIXED  = 2'd1;
  localparam logic [1:0] M_RANDOM = 2'd2;
  localparam logic [1:0] M_HOLD   = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  data = 4'd0;
  logic [1:0]  mode = M_FIXED;
  logic        ready, done;
  logic [7:0]  beat;
  logic [15:0] sum;

  logic        v8 = 1'b0;
  logic [7:0]  d8 = 8'd0;
  logic [1:0]  m8 = M_HOLD;
  logic        ready8, done8;
  logic [7:0]  beat8;
  logic [15:0] sum8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_slave dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .cfg_mode(mode),
    .ready(ready), .burst_done(done), .beat_cnt(beat), .checksum(sum)
  );

  bp_slave #(.DATA_W(8), .BURST_LEN(1)) dut8 (
    .clk(clk), .rst(rst), .valid(v8), .data(d8), .cfg_mode(m8),
    .ready(ready8), .burst_done(done8), .beat_cnt(beat8), .checksum(sum8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_ready, m_hold, m_done;
  int         m_rem, m_beats, m_sum;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic m_reset();
    m_ready = 0; m_hold = 0; m_done = 0;
    m_rem = SMIN; m_beats = 0; m_sum = 0; m_lfsr = SEED;
  endtask

  // Predict the outputs after the next rising edge given this cycle's inputs
  task automatic m_step(input bit v, input int d, input logic [1:0] md);
    int n;
    n = (md == M_RANDOM) ? SMIN + (int'(m_lfsr) % (SMAX - SMIN + 1)) : SMIN;
    m_done = 0;
    if (v && m_ready) begin
      m_sum = (m_sum + d) % 65536;
      if (m_beats == BL - 1) begin m_beats = 0; m_done = 1; end
      else m_beats++;
    end
    if (md == M_HOLD) begin
      m_ready = 0; m_hold = 1;
    end else if (m_ready) begin
      if (m_done && md != M_ALWAYS) begin m_ready = 0; m_rem = n; end
    end else if (md == M_ALWAYS) m_ready = 1;
    else if (m_hold) m_rem = n;
    else if (m_rem == 1) m_ready = 1;
    else m_rem--;
    if (md != M_HOLD) m_hold = 0;
    m_lfsr = ref_lfsr(m_lfsr);
  endtask

  // Drive one cycle at a falling edge, then compare at the next falling edge
  task automatic cycle(input logic v, input logic [3:0] d, input logic [1:0] md);
    valid = v; data = d; mode = md;
    m_step(v, int'(d), md);
    @(negedge clk);
    chk("ready", 32'(ready), 32'(m_ready));
    chk("burst_done", 32'(done), 32'(m_done));
    chk("beat_cnt", 32'(beat), 32'(m_beats));
    chk("checksum", 32'(sum), 32'(m_sum));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; data = 4'd0; mode = M_FIXED;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  int lens_q[$];

  // Collect lengths of low-ready runs in RANDOM mode, skipping the post-reset one
  task automatic measure(input int nruns);
    int run = 0;
    int cyc = 0;
    bit first = 1'b1;
    lens_q.delete();
    while (lens_q.size() < nruns && cyc < 30000) begin
      cycle(1'b1, 4'($urandom), M_RANDOM);
      cyc++;
      if (!ready) run++;
      else if (run > 0) begin
        if (!first) lens_q.push_back(run);
        first = 1'b0;
        run = 0;
      end
    end
    chk("stall_run_count", 32'(lens_q.size()), 32'(nruns));
  endtask

  typedef struct {
    logic [1:0]  md;
    logic        v;
    logic [3:0]  d;
    int          n;
    logic        rdy;
    logic        dn;
    logic [7:0]  bc;
    logic [15:0] cs;
  } vec_t;

  vec_t tbl[15];
  int   hist[int];
  int   saved[40];
  int   ndone;

  initial begin
    tbl[0]  = '{M_FIXED,  1'b0, 4'd0, 4,  1'b0, 1'b0, 8'd0, 16'd0};
    tbl[1]  = '{M_FIXED,  1'b0, 4'd0, 1,  1'b1, 1'b0, 8'd0, 16'd0};
    tbl[2]  = '{M_FIXED,  1'b1, 4'd1, 9,  1'b1, 1'b0, 8'd9, 16'd9};
    tbl[3]  = '{M_FIXED,  1'b1, 4'd1, 1,  1'b0, 1'b1, 8'd0, 16'd10};
    tbl[4]  = '{M_FIXED,  1'b1, 4'd1, 4,  1'b0, 1'b0, 8'd0, 16'd10};
    tbl[5]  = '{M_FIXED,  1'b1, 4'd1, 1,  1'b1, 1'b0, 8'd0, 16'd10};
    tbl[6]  = '{M_FIXED,  1'b1, 4'd3, 4,  1'b1, 1'b0, 8'd4, 16'd22};
    tbl[7]  = '{M_HOLD,   1'b1, 4'd3, 1,  1'b0, 1'b0, 8'd5, 16'd25};
    tbl[8]  = '{M_HOLD,   1'b1, 4'd3, 19, 1'b0, 1'b0, 8'd5, 16'd25};
    tbl[9]  = '{M_FIXED,  1'b1, 4'd3, 5,  1'b0, 1'b0, 8'd5, 16'd25};
    tbl[10] = '{M_FIXED,  1'b1, 4'd3, 1,  1'b1, 1'b0, 8'd5, 16'd25};
    tbl[11] = '{M_ALWAYS, 1'b1, 4'd2, 5,  1'b1, 1'b1, 8'd0, 16'd35};
    tbl[12] = '{M_ALWAYS, 1'b1, 4'd2, 1,  1'b1, 1'b0, 8'd1, 16'd37};
    tbl[13] = '{M_HOLD,   1'b0, 4'd0, 3,  1'b0, 1'b0, 8'd1, 16'd37};
    tbl[14] = '{M_ALWAYS, 1'b0, 4'd0, 1,  1'b1, 1'b0, 8'd1, 16'd37};

    // Reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ready8", 32'(ready8), 32'd0);

    // Directed table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].n) cycle(tbl[i].v, tbl[i].d, tbl[i].md);
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d_beat", i), 32'(beat), 32'(tbl[i].bc));
      chk($sformatf("tbl%0d_sum", i), 32'(sum), 32'(tbl[i].cs));
    end

    // ALWAYS mode: 25 beats of 0xF, ready never drops
    do_reset();
    cycle(1'b1, 4'hF, M_ALWAYS);
    chk("always_first_ready", 32'(ready), 32'd1);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, 4'hF, M_ALWAYS);
      chk("always_ready_held", 32'(ready), 32'd1);
      if (done) ndone++;
    end
    chk("always_done_count", 32'(ndone), 32'd2);
    chk("always_beat", 32'(beat), 32'd5);
    chk("always_sum", 32'(sum), 32'd375);

    // Valid toggling while stalled, then asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'(i % 2), 4'd7, M_FIXED);
    chk("toggle_beat", 32'(beat), 32'd0);
    chk("toggle_sum", 32'(sum), 32'd0);
    cycle(1'b0, 4'd0, M_FIXED);
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'd2, M_FIXED);
    chk("pre_rst_beat", 32'(beat), 32'd7);
    chk("pre_rst_sum", 32'(sum), 32'd14);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_beat", 32'(beat), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < SMIN; i++) cycle(1'b0, 4'd0, M_FIXED);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Randomized traffic with random mode changes
    do_reset();
    begin
      logic [1:0] md = M_FIXED;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
        cycle($urandom_range(0, 3) != 0, 4'($urandom), md);
      end
    end

    // RANDOM stall lengths: range, coverage, repeatability
    do_reset();
    measure(1000);
    foreach (lens_q[i]) begin
      chk("rand_len_in_range", 32'(lens_q[i] >= SMIN && lens_q[i] <= SMAX), 32'd1);
      if (hist.exists(lens_q[i])) hist[lens_q[i]]++;
      else hist[lens_q[i]] = 1;
    end
    for (int k = SMIN; k <= SMAX; k++)
      chk($sformatf("rand_len_hit_%0d", k), 32'(hist.exists(k)), 32'd1);
    for (int i = 0; i < 40; i++) saved[i] = (i < lens_q.size()) ? lens_q[i] : -1;
    do_reset();
    measure(40);
    for (int i = 0; i < 40; i++)
      chk("rand_repeat", 32'((i < lens_q.size()) ? lens_q[i] : -2), 32'(saved[i]));

    // 8-bit data, single-beat bursts, checksum wrap
    do_reset();
    m8 = M_ALWAYS; v8 = 1'b1; d8 = 8'hFF;
    @(negedge clk);
    chk("w8_ready", 32'(ready8), 32'd1);
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("w8_done_count", 32'(ndone), 32'd300);
    chk("w8_beat", 32'(beat8), 32'd0);
    chk("w8_sum", 32'(sum8), 32'd10964);
    v8 = 1'b0; m8 = M_HOLD;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
